// File: rtl/riscv_fetch_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | riscv_fetch_fifo : instruction prefetch buffer with RVC realignment,     |
// |                    branch redirect and hwloop jump handling              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module riscv_fetch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  input  logic        hwloop_jump_i,
  input  logic [31:0] hwloop_target_i,
  output logic        hwloop_branch_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] addr_o,
  output logic [31:0] rdata_o,
  output logic        is_hwlp_o,
  output logic        busy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RV, ABORT} state_t;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_mem [DEPTH];
  logic [PW-1:0]   r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]   r_count, w_count_nxt;
  logic [31:0]     r_fetch_addr, r_addr, r_hwlp_target;
  logic            r_hwlp_pending, r_is_hwlp;

  logic            w_redirect, w_valid, w_comp, w_consume, w_push, w_pop, w_room;
  logic            w_have0, w_have1;
  logic [31:0]     w_target, w_w0, w_w1;

  // A pending hwloop jump behaves as a branch unless a real branch overrides it.
  assign w_redirect = branch_i | r_hwlp_pending;
  assign w_target   = branch_i ? addr_i : r_hwlp_target;

  assign w_w0    = r_mem[r_rd_ptr];
  assign w_w1    = r_mem[r_rd_ptr + PW'(1)];
  assign w_have0 = (r_count != '0);
  assign w_have1 = (r_count > CW'(1));

  always_comb begin
    rdata_o = w_w0;
    w_valid = w_have0;
    if (r_addr[1]) begin
      rdata_o = {w_w1[15:0], w_w0[31:16]};
      w_valid = w_have0 && ((w_w0[17:16] != 2'b11) || w_have1);
    end
  end

  assign valid_o   = w_valid & ~w_redirect;
  assign w_comp    = (rdata_o[1:0] != 2'b11);
  assign w_consume = valid_o & ready_i;
  // Head word retires once the next PC leaves it: any misaligned consume, or a full aligned word.
  assign w_pop     = w_consume & (r_addr[1] | ~w_comp);
  assign w_push    = (r_state == WAIT_RV) & instr_rvalid_i & ~w_redirect;

  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  assign w_room      = (w_count_nxt < CW'(DEPTH));

  assign addr_o          = r_addr;
  assign is_hwlp_o       = r_is_hwlp;
  assign hwloop_branch_o = r_hwlp_pending & ~branch_i;
  assign busy_o          = (r_state != IDLE);
  assign instr_req_o     = (r_state == REQ);
  // A redirect while requesting retargets the request in the same cycle, so no abort is needed.
  assign instr_addr_o    = w_redirect ? {w_target[31:2], 2'b00} : r_fetch_addr;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (req_i && (w_redirect || w_room)) w_state_nxt = REQ;
      end
      REQ: begin
        if (instr_gnt_i) w_state_nxt = WAIT_RV;
      end
      WAIT_RV: begin
        if (instr_rvalid_i)
          w_state_nxt = (req_i && (w_redirect || w_room)) ? REQ : IDLE;
        else if (w_redirect)
          w_state_nxt = ABORT;
      end
      ABORT: begin
        if (instr_rvalid_i) w_state_nxt = req_i ? REQ : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr       <= '0;
      r_wr_ptr       <= '0;
      r_count        <= '0;
      r_fetch_addr   <= '0;
      r_addr         <= '0;
      r_hwlp_target  <= '0;
      r_hwlp_pending <= 1'b0;
      r_is_hwlp      <= 1'b0;
    end else if (w_redirect) begin
      r_rd_ptr       <= '0;
      r_wr_ptr       <= '0;
      r_count        <= '0;
      r_addr         <= w_target;
      r_fetch_addr   <= {w_target[31:2], 2'b00};
      r_hwlp_pending <= 1'b0;
      r_is_hwlp      <= ~branch_i;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= instr_rdata_i;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
        r_fetch_addr    <= r_fetch_addr + 32'd4;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_nxt;
      if (w_consume) begin
        r_addr    <= r_addr + (w_comp ? 32'd2 : 32'd4);
        r_is_hwlp <= 1'b0;
      end
      r_hwlp_pending <= w_consume & hwloop_jump_i;
      if (w_consume & hwloop_jump_i) r_hwlp_target <= hwloop_target_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_fetch_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_riscv_fetch_fifo : directed bench with a one-outstanding cache model  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_riscv_fetch_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0, branch_i = 1'b0, hwloop_jump_i = 1'b0, ready_i = 1'b0;
  logic [31:0] addr_i = '0, hwloop_target_i = '0;
  logic        hwloop_branch_o, instr_req_o, instr_gnt_i, instr_rvalid_i = 1'b0;
  logic [31:0] instr_addr_o, instr_rdata_i = '0, addr_o, rdata_o;
  logic        valid_o, is_hwlp_o, busy_o;

  int          checks = 0, errors = 0;
  int          budget = -1;
  int          grants = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] glog[$];
  logic        saw_bad = 1'b0;
  logic [31:0] mem [logic [31:0]];

  riscv_fetch_fifo #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .branch_i(branch_i), .addr_i(addr_i),
    .hwloop_jump_i(hwloop_jump_i), .hwloop_target_i(hwloop_target_i),
    .hwloop_branch_o(hwloop_branch_o), .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i),
    .instr_addr_o(instr_addr_o), .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .ready_i(ready_i), .valid_o(valid_o), .addr_o(addr_o), .rdata_o(rdata_o),
    .is_hwlp_o(is_hwlp_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  assign instr_gnt_i = instr_req_o;

  function automatic logic [31:0] memrd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0000_0013;
  endfunction

  // Cache model: immediate grant, data one cycle later; budget < 0 means unlimited responses.
  always begin
    @(negedge clk);
    #3;
    instr_rvalid_i = 1'b0;
    if (!rst) begin
      if (busy_o && !instr_req_o && budget != 0) begin
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = memrd(last_addr);
        if (budget > 0) budget--;
      end
      if (instr_req_o) begin
        last_addr = instr_addr_o;
        glog.push_back(instr_addr_o);
        grants++;
      end
      if (valid_o && rdata_o == 32'hDEAD_BEEF) saw_bad = 1'b1;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!valid_o && n < 40) begin step(); n++; end
  endtask

  task automatic quiesce();
    int n = 0;
    req_i = 1'b0; ready_i = 1'b0; budget = -1;
    while (busy_o && n < 50) begin step(); n++; end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL quiesce_busy: got %b expected 0", busy_o); end
  endtask

  task automatic do_branch(input logic [31:0] a);
    branch_i = 1'b1; addr_i = a; req_i = 1'b1;
    #1;
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL branch_valid_low: got %b expected 0", valid_o); end
    step();
    branch_i = 1'b0;
  endtask

  task automatic test_reset();
    step();
    checks++;
    if ({valid_o, busy_o, instr_req_o, is_hwlp_o, hwloop_branch_o} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {valid_o, busy_o, instr_req_o, is_hwlp_o, hwloop_branch_o});
    end
    checks++;
    if (addr_o !== 32'h0 || rdata_o !== 32'h0 || instr_addr_o !== 32'h0) begin
      errors++; $display("FAIL reset_data: addr %h rdata %h iaddr %h expected 0", addr_o, rdata_o, instr_addr_o);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_sequential();
    int n;
    quiesce();
    do_branch(32'h100);
    repeat (25) step();
    ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      n = 0;
      while (!valid_o && n < 40) begin step(); n++; end
      checks++;
      if (valid_o !== 1'b1 || addr_o !== 32'h100 + 32'(4*k) || rdata_o !== 32'h13) begin
        errors++; $display("FAIL seq_word%0d: valid %b addr %h rdata %h expected addr %h rdata 00000013", k, valid_o, addr_o, rdata_o, 32'h100 + 32'(4*k));
      end
      if (k < 4) begin
        checks++;
        if (n !== 0) begin errors++; $display("FAIL seq_gap%0d: waited %0d cycles expected 0", k, n); end
      end
      step();
    end
    ready_i = 1'b0;
  endtask

  task automatic test_rvc();
    quiesce();
    mem[32'h200] = 32'h4501_0001;
    mem[32'h204] = 32'h0000_0513;
    budget = 1;
    ready_i = 1'b1;
    do_branch(32'h200);
    wait_valid();
    checks++;
    if (valid_o !== 1'b1 || addr_o !== 32'h200 || rdata_o !== 32'h4501_0001) begin
      errors++; $display("FAIL rvc_200: valid %b addr %h rdata %h expected 1 00000200 45010001", valid_o, addr_o, rdata_o);
    end
    step();
    checks++;
    if (valid_o !== 1'b1 || addr_o !== 32'h202 || rdata_o[15:0] !== 16'h4501) begin
      errors++; $display("FAIL rvc_202: valid %b addr %h rdata %h expected 1 00000202 4501", valid_o, addr_o, rdata_o[15:0]);
    end
    step();
    repeat (3) begin
      checks++;
      if (valid_o !== 1'b0 || addr_o !== 32'h204) begin
        errors++; $display("FAIL rvc_204_wait: valid %b addr %h expected 0 00000204", valid_o, addr_o);
      end
      step();
    end
    budget = 1;
    wait_valid();
    checks++;
    if (valid_o !== 1'b1 || addr_o !== 32'h204 || rdata_o !== 32'h0000_0513) begin
      errors++; $display("FAIL rvc_204: valid %b addr %h rdata %h expected 1 00000204 00000513", valid_o, addr_o, rdata_o);
    end
  endtask

  task automatic test_misaligned();
    int seen = 0;
    quiesce();
    mem[32'h300] = 32'h0513_ABCD;
    mem[32'h304] = 32'h0001_0000;
    budget = 1;
    ready_i = 1'b1;
    do_branch(32'h302);
    repeat (8) begin if (valid_o) seen++; step(); end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL mis_wait_w1: valid seen %0d times expected 0", seen); end
    budget = 1;
    wait_valid();
    checks++;
    if (valid_o !== 1'b1 || addr_o !== 32'h302 || rdata_o !== 32'h0000_0513) begin
      errors++; $display("FAIL mis_302: valid %b addr %h rdata %h expected 1 00000302 00000513", valid_o, addr_o, rdata_o);
    end
    step();
    checks++;
    if (valid_o !== 1'b1 || addr_o !== 32'h306 || rdata_o[15:0] !== 16'h0001) begin
      errors++; $display("FAIL mis_306: valid %b addr %h rdata %h expected 1 00000306 0001", valid_o, addr_o, rdata_o[15:0]);
    end
  endtask

  task automatic test_abort();
    int n = 0;
    int g0;
    quiesce();
    mem[32'h600] = 32'hDEAD_BEEF;
    mem[32'h400] = 32'h0000_0093;
    saw_bad = 1'b0;
    budget = 0;
    ready_i = 1'b1;
    do_branch(32'h600);
    while (!(busy_o && !instr_req_o) && n < 20) begin step(); n++; end
    checks++;
    if (busy_o !== 1'b1 || instr_req_o !== 1'b0) begin
      errors++; $display("FAIL abort_wait_rv: busy %b req %b expected 1 0", busy_o, instr_req_o);
    end
    g0 = glog.size();
    do_branch(32'h400);
    checks++;
    if (busy_o !== 1'b1 || instr_req_o !== 1'b0) begin
      errors++; $display("FAIL abort_state: busy %b req %b expected 1 0", busy_o, instr_req_o);
    end
    budget = -1;
    wait_valid();
    checks++;
    if (valid_o !== 1'b1 || addr_o !== 32'h400 || rdata_o !== 32'h0000_0093) begin
      errors++; $display("FAIL abort_target: valid %b addr %h rdata %h expected 1 00000400 00000093", valid_o, addr_o, rdata_o);
    end
    checks++;
    if (glog.size() <= g0 || glog[g0] !== 32'h400) begin
      errors++; $display("FAIL abort_req_addr: got %h expected 00000400", (glog.size() > g0) ? glog[g0] : 32'hFFFF_FFFF);
    end
    checks++;
    if (saw_bad !== 1'b0) begin errors++; $display("FAIL abort_dropped: stale word seen %b expected 0", saw_bad); end
  endtask

  task automatic test_full();
    quiesce();
    grants = 0;
    do_branch(32'h700);
    repeat (30) step();
    checks++;
    if (grants !== 4 || instr_req_o !== 1'b0 || busy_o !== 1'b0 || valid_o !== 1'b1) begin
      errors++; $display("FAIL full_stop: grants %0d req %b busy %b valid %b expected 4 0 0 1", grants, instr_req_o, busy_o, valid_o);
    end
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    repeat (20) step();
    checks++;
    if (grants !== 5 || busy_o !== 1'b0 || addr_o !== 32'h704) begin
      errors++; $display("FAIL full_refill: grants %0d busy %b addr %h expected 5 0 00000704", grants, busy_o, addr_o);
    end
  endtask

  task automatic find_50c();
    int n = 0;
    while (!(valid_o && addr_o == 32'h50C) && n < 60) begin step(); n++; end
    checks++;
    if (valid_o !== 1'b1 || addr_o !== 32'h50C || is_hwlp_o !== 1'b0) begin
      errors++; $display("FAIL hwlp_reach_end: valid %b addr %h is_hwlp %b expected 1 0000050c 0", valid_o, addr_o, is_hwlp_o);
    end
    hwloop_jump_i = 1'b1; hwloop_target_i = 32'h500;
    step();
    hwloop_jump_i = 1'b0;
  endtask

  task automatic test_hwloop();
    quiesce();
    ready_i = 1'b1;
    do_branch(32'h500);
    find_50c();
    checks++;
    if (hwloop_branch_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++; $display("FAIL hwlp_pulse: pulse %b valid %b expected 1 0", hwloop_branch_o, valid_o);
    end
    step();
    checks++;
    if (hwloop_branch_o !== 1'b0) begin errors++; $display("FAIL hwlp_pulse_end: got %b expected 0", hwloop_branch_o); end
    wait_valid();
    checks++;
    if (valid_o !== 1'b1 || addr_o !== 32'h500 || is_hwlp_o !== 1'b1) begin
      errors++; $display("FAIL hwlp_first: valid %b addr %h is_hwlp %b expected 1 00000500 1", valid_o, addr_o, is_hwlp_o);
    end
    step();
    wait_valid();
    checks++;
    if (valid_o !== 1'b1 || addr_o !== 32'h504 || is_hwlp_o !== 1'b0) begin
      errors++; $display("FAIL hwlp_second: valid %b addr %h is_hwlp %b expected 1 00000504 0", valid_o, addr_o, is_hwlp_o);
    end
    step();
    find_50c();
    branch_i = 1'b1; addr_i = 32'h800;
    #1;
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL hwlp_branch_pulse_valid: got %b expected 0", valid_o); end
    step();
    branch_i = 1'b0;
    wait_valid();
    checks++;
    if (valid_o !== 1'b1 || addr_o !== 32'h800 || is_hwlp_o !== 1'b0) begin
      errors++; $display("FAIL hwlp_branch_wins: valid %b addr %h is_hwlp %b expected 1 00000800 0", valid_o, addr_o, is_hwlp_o);
    end
  endtask

  task automatic test_reset_midflight();
    quiesce();
    budget = 0;
    do_branch(32'h900);
    step();
    rst = 1'b1;
    #1;
    checks++;
    if ({valid_o, busy_o, instr_req_o} !== 3'b0 || addr_o !== 32'h0) begin
      errors++; $display("FAIL reset_midflight: flags %b addr %h expected 000 00000000", {valid_o, busy_o, instr_req_o}, addr_o);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_rvc();
    test_misaligned();
    test_abort();
    test_full();
    test_hwloop();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
